// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: stall generation and forwarding-mux selects.
// Optional stall-cycle counter port stall_cnt is built when HAZARD_STAT_EN is defined.
module hazard_ctrl #(
  parameter int AW = 5
`ifdef HAZARD_STAT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          d_j_l,
  input  logic          d_calc_r,
  input  logic          d_calc_i,
  input  logic          d_lui,
  input  logic          d_load,
  input  logic          d_store,
  input  logic          d_branch,
  input  logic          d_jr,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [AW-1:0] d_rd,
  output logic          stall,
  output logic [1:0]    fwd_d_rs,
  output logic [1:0]    fwd_d_rt,
  output logic [1:0]    fwd_e_rs,
  output logic [1:0]    fwd_e_rt,
  output logic          fwd_m_rt
`ifdef HAZARD_STAT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  function automatic logic [1:0] sat_dec(input logic [1:0] x);
    return (x == 2'd0) ? 2'd0 : x - 2'd1;
  endfunction

  logic [7:0]    cls;
  logic [AW-1:0] d_a3;
  logic [1:0]    d_tnew, tuse_rs, tuse_rt;

  // _p0 = E stage, _p1 = M stage, _p2 = W stage
  logic [AW-1:0] a3_p0, a3_p1, a3_p2;
  logic [1:0]    tnew_p0, tnew_p1, tnew_p2;
  logic [AW-1:0] rs_p0, rt_p0, rt_p1;

  assign cls = {d_j_l, d_calc_r, d_calc_i, d_lui, d_load, d_store, d_branch, d_jr};

  // D-stage decode; anything other than exactly one class flag behaves as a no-op
  always_comb begin
    d_a3    = '0;
    d_tnew  = 2'd0;
    tuse_rs = 2'd3;
    tuse_rt = 2'd3;
    if ($onehot(cls)) begin
      if (d_calc_r) begin
        d_a3 = d_rd; d_tnew = 2'd1; tuse_rs = 2'd1; tuse_rt = 2'd1;
      end else if (d_calc_i) begin
        d_a3 = d_rt; d_tnew = 2'd1; tuse_rs = 2'd1;
      end else if (d_lui) begin
        d_a3 = d_rt; d_tnew = 2'd1;
      end else if (d_load) begin
        d_a3 = d_rt; d_tnew = 2'd2; tuse_rs = 2'd1;
      end else if (d_store) begin
        tuse_rs = 2'd1; tuse_rt = 2'd2;
      end else if (d_branch) begin
        tuse_rs = 2'd0; tuse_rt = 2'd0;
      end else if (d_jr) begin
        tuse_rs = 2'd0;
      end else begin
        d_a3 = AW'(31); d_tnew = 2'd0;
      end
    end
  end

  function automatic logic needs_wait(input logic [AW-1:0] src, input logic [1:0] tuse,
                                      input logic [AW-1:0] ea3, input logic [1:0] etn,
                                      input logic [AW-1:0] ma3, input logic [1:0] mtn);
    return (src != '0) && (((src == ea3) && (etn > tuse)) || ((src == ma3) && (mtn > tuse)));
  endfunction

  function automatic logic ready_hit(input logic [AW-1:0] src, input logic [AW-1:0] a3,
                                     input logic [1:0] tn);
    return (a3 != '0) && (src == a3) && (tn == 2'd0);
  endfunction

  always_comb begin
    stall = needs_wait(d_rs, tuse_rs, a3_p0, tnew_p0, a3_p1, tnew_p1) ||
            needs_wait(d_rt, tuse_rt, a3_p0, tnew_p0, a3_p1, tnew_p1);

    fwd_d_rs = ready_hit(d_rs, a3_p0, tnew_p0) ? 2'd1 :
               ready_hit(d_rs, a3_p1, tnew_p1) ? 2'd2 : 2'd0;
    fwd_d_rt = ready_hit(d_rt, a3_p0, tnew_p0) ? 2'd1 :
               ready_hit(d_rt, a3_p1, tnew_p1) ? 2'd2 : 2'd0;
    fwd_e_rs = ready_hit(rs_p0, a3_p1, tnew_p1) ? 2'd2 :
               ready_hit(rs_p0, a3_p2, tnew_p2) ? 2'd3 : 2'd0;
    fwd_e_rt = ready_hit(rt_p0, a3_p1, tnew_p1) ? 2'd2 :
               ready_hit(rt_p0, a3_p2, tnew_p2) ? 2'd3 : 2'd0;
    fwd_m_rt = ready_hit(rt_p1, a3_p2, tnew_p2);
  end

  // D -> E -> M -> W record pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      a3_p0 <= '0; tnew_p0 <= 2'd0; rs_p0 <= '0; rt_p0 <= '0;
      a3_p1 <= '0; tnew_p1 <= 2'd0; rt_p1 <= '0;
      a3_p2 <= '0; tnew_p2 <= 2'd0;
    end else begin
      if (stall) begin
        a3_p0 <= '0; tnew_p0 <= 2'd0; rs_p0 <= '0; rt_p0 <= '0;
      end else begin
        a3_p0 <= d_a3; tnew_p0 <= d_tnew; rs_p0 <= d_rs; rt_p0 <= d_rt;
      end
      a3_p1   <= a3_p0;
      tnew_p1 <= sat_dec(tnew_p0);
      // a value already taken from M at E is in the E/M register; its producer sits in W next
      // cycle and must not be forwarded a second time
      rt_p1   <= (fwd_e_rt == 2'd2) ? '0 : rt_p0;
      a3_p2   <= a3_p1;
      tnew_p2 <= sat_dec(tnew_p1);
    end
  end

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction sequences with hand-computed selects.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam logic [7:0] NOP = 8'h00, JL = 8'h80, CR = 8'h40, CI = 8'h20, LUI = 8'h10,
                         LD = 8'h08, ST = 8'h04, BR = 8'h02, JR = 8'h01;

  logic clk = 1'b0;
  logic reset;
  logic d_j_l, d_calc_r, d_calc_i, d_lui, d_load, d_store, d_branch, d_jr;
  logic [AW-1:0] d_rs, d_rt, d_rd;
  logic stall, fwd_m_rt;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [31:0] stall_cnt_v;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt;
  assign stall_cnt_v = stall_cnt;
`else
  assign stall_cnt_v = '0;
`endif

  hazard_ctrl #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .d_j_l(d_j_l), .d_calc_r(d_calc_r), .d_calc_i(d_calc_i), .d_lui(d_lui),
    .d_load(d_load), .d_store(d_store), .d_branch(d_branch), .d_jr(d_jr),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
`ifdef HAZARD_STAT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    logic st;
    logic [1:0] drs, drt, ers, ert;
    logic mrt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int vec = 0;

  task automatic step(input logic [7:0] f, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic [AW-1:0] rd, input logic rst,
                      input logic est, input logic [1:0] edrs, input logic [1:0] edrt,
                      input logic [1:0] eers, input logic [1:0] eert, input logic emrt,
                      input logic [31:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    {d_j_l, d_calc_r, d_calc_i, d_lui, d_load, d_store, d_branch, d_jr} = f;
    d_rs = rs; d_rt = rt; d_rd = rd; reset = rst;
    e.idx = vec; e.st = est; e.drs = edrs; e.drt = edrt; e.ers = eers; e.ert = eert;
    e.mrt = emrt; e.cnt = ecnt;
    sb.push_back(e);
    vec++;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL v%0d.%s actual=%0d required=%0d", idx, name, act, req);
    end
  endtask

  // monitor: combinational outputs are presented every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("stall", e.idx, 32'(stall), 32'(e.st));
      chk("fwd_d_rs", e.idx, 32'(fwd_d_rs), 32'(e.drs));
      chk("fwd_d_rt", e.idx, 32'(fwd_d_rt), 32'(e.drt));
      chk("fwd_e_rs", e.idx, 32'(fwd_e_rs), 32'(e.ers));
      chk("fwd_e_rt", e.idx, 32'(fwd_e_rt), 32'(e.ert));
      chk("fwd_m_rt", e.idx, 32'(fwd_m_rt), 32'(e.mrt));
`ifdef HAZARD_STAT_EN
      chk("stall_cnt", e.idx, stall_cnt_v, e.cnt);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {d_j_l, d_calc_r, d_calc_i, d_lui, d_load, d_store, d_branch, d_jr} = '0;
    d_rs = '0; d_rt = '0; d_rd = '0;
    repeat (2) @(posedge clk);
    //     flags rs  rt  rd rst  st drs drt ers ert mrt cnt
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 0);  // reset state
    // lw $1 ; add $2,$1,$3
    step(LD,   4,  1,  0, 0,   0, 0, 0, 0, 0, 0, 0);
    step(CR,   1,  3,  2, 0,   1, 0, 0, 0, 0, 0, 0);
    step(CR,   1,  3,  2, 0,   0, 0, 0, 0, 0, 0, 1);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 3, 0, 0, 1);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 1);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 1);
    // ori $1 ; beq $1,$0
    step(CI,   0,  1,  0, 0,   0, 0, 0, 0, 0, 0, 1);
    step(BR,   1,  0,  0, 0,   1, 0, 0, 0, 0, 0, 1);
    step(BR,   1,  0,  0, 0,   0, 2, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 3, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    // jal ; jr $31
    step(JL,   0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(JR,  31,  0,  0, 0,   0, 1, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 2, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    // add $5,$1,$2 ; sw $5,0($6)
    step(CR,   1,  2,  5, 0,   0, 0, 0, 0, 0, 0, 2);
    step(ST,   6,  5,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 2, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    // lw $7 ; sw $7 : store data comes from W in M
    step(LD,   0,  7,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(ST,   0,  7,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 1, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    // ori $0 ; add $2,$0,$0
    step(CI,   0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(CR,   0,  0,  2, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    // two class flags at once act as a no-op
    step(LD|CR, 0, 1,  1, 0,   0, 0, 0, 0, 0, 0, 2);
    step(CR,   1,  1,  2, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    // lw $1 ; beq $1 with reset in the first stall cycle
    step(LD,   0,  1,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(BR,   1,  0,  0, 1,   1, 0, 0, 0, 0, 0, 2);
    step(BR,   1,  0,  0, 0,   0, 0, 0, 0, 0, 0, 0);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 0);
    // lw $1 ; beq $1 without reset: two stall cycles
    step(LD,   0,  1,  0, 0,   0, 0, 0, 0, 0, 0, 0);
    step(BR,   1,  0,  0, 0,   1, 0, 0, 0, 0, 0, 0);
    step(BR,   1,  0,  0, 0,   1, 0, 0, 0, 0, 0, 1);
    step(BR,   1,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    step(NOP,  0,  0,  0, 0,   0, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
